// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: req/ack data-memory bus transaction with pipeline stall.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16,
  parameter int TCNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [1:0]       MemSizeM,
  input  logic             MemSignedM,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic             DmemReq,
  output logic             DmemWe,
  output logic [WIDTH-1:0] DmemAddr,
  output logic [3:0]       DmemBe,
  output logic [WIDTH-1:0] DmemWdata,
  input  logic [WIDTH-1:0] DmemRdata,
  input  logic             DmemAck,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             StallM,
  output logic             BusErrM,
  output logic             MisalignM
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [TCNT_W-1:0] WDOG_LAST = TCNT_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [TCNT_W-1:0] wdog_q;
  logic [1:0]        addr_lo_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              load_q;

  logic              access;
  logic              misaligned;
  logic [3:0]        be_d;
  logic [WIDTH-1:0]  wdata_d;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [WIDTH-1:0]  load_ext;

  assign access = MemReadM | MemWriteM;
  assign StallM = (state_q == REQ) || ((state_q == IDLE) && access);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = ((MemSizeM == 2'b01) && ALUOutM[0]) ||
                      (MemSizeM[1] && (ALUOutM[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteDataM;
    case (MemSizeM)
      2'b00: begin
        be_d    = 4'b0001 << ALUOutM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_d    = ALUOutM[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the launch-time low address bits, since DmemAddr is word-aligned.
  always_comb begin
    rd_byte  = DmemRdata[{addr_lo_q, 3'b000} +: 8];
    rd_half  = addr_lo_q[1] ? DmemRdata[31:16] : DmemRdata[15:0];
    load_ext = DmemRdata;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wdog_q    <= '0;
      addr_lo_q <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      load_q    <= 1'b0;
      DmemReq   <= 1'b0;
      DmemWe    <= 1'b0;
      DmemAddr  <= '0;
      DmemBe    <= '0;
      DmemWdata <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
      MisalignM <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            ReadDataM <= '0;
            BusErrM   <= 1'b0;
            if (misaligned) begin
              MisalignM <= 1'b1;
              state_q   <= DONE;
            end else begin
              DmemAddr  <= {ALUOutM[WIDTH-1:2], 2'b00};
              DmemBe    <= be_d;
              DmemWdata <= wdata_d;
              DmemWe    <= MemWriteM;
              DmemReq   <= 1'b1;
              wdog_q    <= '0;
              addr_lo_q <= ALUOutM[1:0];
              size_q    <= MemSizeM;
              signed_q  <= MemSignedM;
              load_q    <= MemReadM & ~MemWriteM;
              state_q   <= REQ;
            end
          end
        end
        REQ: begin
          if (DmemAck) begin
            DmemReq <= 1'b0;
            if (load_q) ReadDataM <= load_ext;
            state_q <= DONE;
          end else if (wdog_q == WDOG_LAST) begin
            DmemReq   <= 1'b0;
            ReadDataM <= '0;
            BusErrM   <= 1'b1;
            state_q   <= DONE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        DONE: begin
          BusErrM   <= 1'b0;
          MisalignM <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; each scenario task compares against hand-computed values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0, MemSignedM = 1'b0;
  logic [1:0]  MemSizeM = 2'b00;
  logic [31:0] ALUOutM = '0, WriteDataM = '0, DmemRdata = '0;
  logic        DmemAck = 1'b0;
  logic        DmemReq, DmemWe, StallM, BusErrM, MisalignM;
  logic [31:0] DmemAddr, DmemWdata, ReadDataM;
  logic [3:0]  DmemBe;

  int n_chk  = 0;
  int n_pass = 0;

  // Observations from the most recent access.
  int          o_stalls, o_reqs;
  logic        o_done, o_we, o_berr, o_mis, o_req_in_done;
  logic [31:0] o_rd, o_addr, o_wdata;
  logic [3:0]  o_be;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .MemSizeM(MemSizeM), .MemSignedM(MemSignedM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .DmemReq(DmemReq), .DmemWe(DmemWe),
    .DmemAddr(DmemAddr), .DmemBe(DmemBe), .DmemWdata(DmemWdata),
    .DmemRdata(DmemRdata), .DmemAck(DmemAck), .ReadDataM(ReadDataM),
    .StallM(StallM), .BusErrM(BusErrM), .MisalignM(MisalignM)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  // Drives one access and records what the DUT did; ack_after=0 means never ack.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_after, input logic [31:0] rdata);
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; MemSizeM = sz; MemSignedM = sg;
    ALUOutM = addr; WriteDataM = wd; DmemAck = 1'b0;
    o_stalls = 0; o_reqs = 0; o_done = 1'b0;
    o_be = '0; o_addr = '0; o_wdata = '0; o_we = 1'b0;
    o_rd = '0; o_berr = 1'b0; o_mis = 1'b0; o_req_in_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (DmemReq) begin
        o_reqs++;
        o_be = DmemBe; o_addr = DmemAddr; o_wdata = DmemWdata; o_we = DmemWe;
        DmemAck = (o_reqs == ack_after);
        DmemRdata = rdata;
      end else begin
        DmemAck = 1'b0;
      end
      if (StallM) begin
        o_stalls++;
      end else begin
        o_rd = ReadDataM; o_berr = BusErrM; o_mis = MisalignM; o_req_in_done = DmemReq;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        o_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    DmemAck = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if ({DmemReq, DmemWe, DmemBe, StallM, BusErrM, MisalignM} !== 9'b0) $display("FAIL reset_ctl got %b exp 0", {DmemReq, DmemWe, DmemBe, StallM, BusErrM, MisalignM}); else n_pass++;
    n_chk++; if ({DmemAddr, DmemWdata, ReadDataM} !== 96'b0) $display("FAIL reset_data got %h exp 0", {DmemAddr, DmemWdata, ReadDataM}); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    n_chk++; if (o_done !== 1'b1) $display("FAIL wl_done got %b exp 1", o_done); else n_pass++;
    n_chk++; if (o_stalls != 2) $display("FAIL wl_stalls got %0d exp 2", o_stalls); else n_pass++;
    n_chk++; if (o_rd !== 32'hDEADBEEF) $display("FAIL wl_rdata got %h exp deadbeef", o_rd); else n_pass++;
    n_chk++; if (o_be !== 4'b1111 || o_addr !== 32'h100 || o_we !== 1'b0) $display("FAIL wl_bus got be=%b addr=%h we=%b exp 1111 100 0", o_be, o_addr, o_we); else n_pass++;
    n_chk++; if (o_req_in_done !== 1'b0) $display("FAIL wl_req_drop got %b exp 0", o_req_in_done); else n_pass++;
  endtask

  task automatic test_byte_half_load();
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h80112233);
    n_chk++; if (o_be !== 4'b1000 || o_rd !== 32'hFFFFFF80) $display("FAIL sbyte got be=%b rd=%h exp 1000 ffffff80", o_be, o_rd); else n_pass++;
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'h80112233);
    n_chk++; if (o_rd !== 32'h00000080) $display("FAIL ubyte got %h exp 00000080", o_rd); else n_pass++;
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1, 32'h80112233);
    n_chk++; if (o_be !== 4'b0010 || o_rd !== 32'h00000022) $display("FAIL sbyte_pos got be=%b rd=%h exp 0010 00000022", o_be, o_rd); else n_pass++;
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1, 32'h80017FFF);
    n_chk++; if (o_be !== 4'b1100 || o_rd !== 32'hFFFF8001) $display("FAIL shalf_hi got be=%b rd=%h exp 1100 ffff8001", o_be, o_rd); else n_pass++;
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 1, 32'h80017FFF);
    n_chk++; if (o_be !== 4'b0011 || o_rd !== 32'h00007FFF) $display("FAIL shalf_lo got be=%b rd=%h exp 0011 00007fff", o_be, o_rd); else n_pass++;
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1, 32'h80017FFF);
    n_chk++; if (o_rd !== 32'h00008001) $display("FAIL uhalf got %h exp 00008001", o_rd); else n_pass++;
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'h55555555);
    n_chk++; if (o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD) $display("FAIL hstore_bus got we=%b be=%b wd=%h exp 1 1100 abcdabcd", o_we, o_be, o_wdata); else n_pass++;
    n_chk++; if (o_stalls != 4 || o_rd !== 32'h0) $display("FAIL hstore_stall got stalls=%0d rd=%h exp 4 0", o_stalls, o_rd); else n_pass++;
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h001, 32'h123456A5, 1, 32'h0);
    n_chk++; if (o_be !== 4'b0010 || o_wdata !== 32'hA5A5A5A5 || o_addr !== 32'h0) $display("FAIL bstore got be=%b wd=%h addr=%h exp 0010 a5a5a5a5 0", o_be, o_wdata, o_addr); else n_pass++;
    run_access(1'b1, 1'b1, 2'b11, 1'b0, 32'h308, 32'hCAFEF00D, 1, 32'h11111111);
    n_chk++; if (o_we !== 1'b1 || o_be !== 4'b1111 || o_wdata !== 32'hCAFEF00D || o_rd !== 32'h0) $display("FAIL rw_store got we=%b be=%b wd=%h rd=%h exp 1 1111 cafef00d 0", o_we, o_be, o_wdata, o_rd); else n_pass++;
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0, 32'h77777777);
    n_chk++; if (o_reqs != 16 || o_stalls != 17) $display("FAIL to_cycles got reqs=%0d stalls=%0d exp 16 17", o_reqs, o_stalls); else n_pass++;
    n_chk++; if (o_berr !== 1'b1 || o_rd !== 32'h0 || o_req_in_done !== 1'b0) $display("FAIL to_flags got berr=%b rd=%h req=%b exp 1 0 0", o_berr, o_rd, o_req_in_done); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (BusErrM !== 1'b0) $display("FAIL to_berr_clear got %b exp 0", BusErrM); else n_pass++;
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1, 32'h12345678);
    n_chk++; if (o_berr !== 1'b0 || o_rd !== 32'h12345678 || o_stalls != 2) $display("FAIL to_recover got berr=%b rd=%h stalls=%0d exp 0 12345678 2", o_berr, o_rd, o_stalls); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemReadM = 1'b1; MemSizeM = 2'b10; ALUOutM = 32'h300;
    @(negedge clk); #1;
    n_chk++; if (DmemReq !== 1'b1) $display("FAIL rm_req got %b exp 1", DmemReq); else n_pass++;
    rst_n = 1'b0; MemReadM = 1'b0;
    #1;
    n_chk++; if ({DmemReq, DmemBe, StallM} !== 6'b0 || DmemAddr !== 32'h0) $display("FAIL rm_clear got req=%b be=%b stall=%b addr=%h exp 0", DmemReq, DmemBe, StallM, DmemAddr); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; DmemAck = 1'b1; DmemRdata = 32'hFFFFFFFF;
    @(negedge clk);
    DmemAck = 1'b0;
    #1;
    n_chk++; if (DmemReq !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0 || BusErrM !== 1'b0) $display("FAIL rm_ack_ignored got req=%b stall=%b rd=%h berr=%b exp 0 0 0 0", DmemReq, StallM, ReadDataM, BusErrM); else n_pass++;
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1, 32'hA5A55A5A);
    n_chk++; if (o_stalls != 2 || o_rd !== 32'hA5A55A5A) $display("FAIL rm_next got stalls=%0d rd=%h exp 2 a5a55a5a", o_stalls, o_rd); else n_pass++;
  endtask

  task automatic test_misalign();
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1, 32'h0BADF00D);
`ifdef MEM_MISALIGN_CHECK_EN
    n_chk++; if (o_reqs != 0 || o_stalls != 1) $display("FAIL mis_noreq got reqs=%0d stalls=%0d exp 0 1", o_reqs, o_stalls); else n_pass++;
    n_chk++; if (o_mis !== 1'b1 || o_rd !== 32'h0) $display("FAIL mis_flag got mis=%b rd=%h exp 1 0", o_mis, o_rd); else n_pass++;
`else
    n_chk++; if (o_reqs != 1 || o_addr !== 32'h100 || o_be !== 4'b1111) $display("FAIL mis_off_bus got reqs=%0d addr=%h be=%b exp 1 100 1111", o_reqs, o_addr, o_be); else n_pass++;
    n_chk++; if (o_mis !== 1'b0 || o_rd !== 32'h0BADF00D) $display("FAIL mis_off_flag got mis=%b rd=%h exp 0 0badf00d", o_mis, o_rd); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_half_load();
    test_store();
    test_timeout();
    test_reset_mid();
    test_misalign();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store controller. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It takes the address (ALUOutM), store data and memory controls, and runs a req/ack transaction on the data-memory bus. While the transaction is pending it stalls the pipeline. For loads it returns aligned and extended read data (ReadDataM) to the MEM/WB register.

Parameters:
WIDTH, 32, datapath width; only 32 supported (4 byte lanes)
TIMEOUT, 16, max cycles waiting for DmemAck before abort with bus error (≥1)
TCNT_W, 5, watchdog counter width; must hold TIMEOUT

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
MemReadM  input  1  load in MEM stage
MemWriteM  input  1  store in MEM stage
MemSizeM  input  2  00 byte, 01 half, 10 word, 11 treated as word
MemSignedM  input  1  1 = sign-extend loads, 0 = zero-extend
ALUOutM  input  WIDTH  byte address
WriteDataM  input  WIDTH  store data, right-justified
DmemReq  output  1  bus request, held until ack or timeout
DmemWe  output  1  1 = write
DmemAddr  output  WIDTH  word-aligned address ({ALUOutM[31:2],2'b00})
DmemBe  output  4  byte enables, little-endian
DmemWdata  output  WIDTH  lane-replicated store data
DmemRdata  input  WIDTH  read data, valid with DmemAck
DmemAck  input  1  one-cycle transaction completion
ReadDataM  output  WIDTH  extended load result
StallM  output  1  freeze IF..MEM stages and EX/MEM register
BusErrM  output  1  timeout flag for current access
MisalignM  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Async reset (rst_n=0): state IDLE; DmemReq, DmemWe, DmemBe, DmemAddr, DmemWdata, ReadDataM, BusErrM, MisalignM = 0; watchdog = 0. Takes effect mid-transaction; an ack arriving after reset is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - No access (MemReadM=MemWriteM=0): StallM=0, stay.
  - Access: StallM=1 (combinational, same cycle). Register DmemAddr/Be/Wdata/We, set DmemReq=1, clear watchdog, go REQ.
- REQ:
  - StallM=1, bus outputs stable.
  - DmemAck=1: DmemReq←0. For a load, capture the extended DmemRdata into ReadDataM. Go DONE.
  - No ack: watchdog++. At watchdog==TIMEOUT-1 without ack: DmemReq←0, ReadDataM←0, BusErrM←1, go DONE.
- DONE: StallM=0 so the pipeline advances and MEM/WB samples ReadDataM, BusErrM and MisalignM. Next cycle go IDLE unconditionally; the same instruction is never relaunched. BusErrM and MisalignM clear on leaving DONE.
- Minimum occupancy: 3 cycles (IDLE, REQ+ack, DONE); 2 stall cycles.
- MemReadM & MemWriteM both 1: handled as store; ReadDataM=0.
- Stores: ReadDataM←0 in DONE.
- DmemAck in IDLE or DONE is ignored.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- Store data: byte → {4{wd[7:0]}}; half → {2{wd[15:0]}}; word as-is.
- Load extraction:
  - byte lane = Rdata[8*addr[1:0] +: 8]
  - half = addr[1] ? Rdata[31:16] : Rdata[15:0]
  - extend to 32 bits per MemSignedM; word loads pass through.

Optional Feature:
Macro MEM_MISALIGN_CHECK_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]≠00, is misaligned. No bus request is issued: IDLE→DONE directly (1 stall cycle). In DONE, MisalignM=1 and ReadDataM=0; stores write nothing.
- Undefined: MisalignM tied 0. Offending low address bits are ignored: half uses addr[1] only, word uses lanes 1111. The access proceeds normally.

Test Plan:
- Word load, addr 0x100, ack on first REQ cycle, Rdata 0xDEADBEEF → StallM high 2 cycles; ReadDataM=0xDEADBEEF in DONE; DmemBe=1111, DmemAddr=0x100.
- Signed byte load, addr 0x103, Rdata 0x80112233 → Be=1000, ReadDataM=0xFFFFFF80; repeat unsigned → 0x00000080.
- Half store, addr 0x202, WriteDataM 0x0000ABCD, ack after 3 cycles → DmemWe=1, Be=1100, Wdata=0xABCDABCD, StallM high 4 cycles.
- No ack, TIMEOUT=16 → DmemReq drops after 16 REQ cycles; BusErrM=1 for one cycle, ReadDataM=0; next access proceeds normally.
- rst_n pulsed low during REQ, then DmemAck arrives → all outputs 0, state IDLE, ack ignored, StallM=0.
- With MEM_MISALIGN_CHECK_EN: word load at 0x101 → no DmemReq, 1 stall cycle, MisalignM=1; without macro: request issued at 0x100 with Be=1111.
